// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_pkg;

  // Which source supplies the next fetch PC.
  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_SEQ,
    SRC_RAS,
    SRC_BR,
    SRC_EXC
  } pc_src_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'hFFFF_FFFC;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0008;
  localparam int          DEF_STEP      = 4;
  localparam int          DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Latency: top/empty reflect pushes and pops one clk edge after they are issued.
// Backpressure: none; the caller qualifies push/pop, and flush empties the stack.
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   top_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            swap;

  // wr_ptr always points one past the top; with a full stack that is the oldest slot.
  assign top_ptr = wr_ptr - PW'(1);
  assign top     = mem[top_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign swap    = push && pop && !empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (swap) begin
      wr_ptr <= wr_ptr;
      count  <= count;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - CW'(1);
    end
  end

  // Entry storage: a simultaneous push+pop replaces the top in place.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (swap)      mem[top_ptr] <= push_addr;
      else if (push) mem[wr_ptr]  <= push_addr;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: exc > branch > RAS pop > sequential > hold; optional RAS via PC_GEN_RAS_EN.
// Latency: one clk edge from request to pc; pc_next is the combinational preview.
// Backpressure: pc_write=0 stalls sequential/RAS sources; exc and br_taken always win.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [XLEN-1:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int              STEP      = DEF_STEP,
  parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            exc,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            redirected,
  output logic            misalign,
  output logic            ras_empty
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(STEP - 1);

  pc_src_t         src;
  logic [XLEN-1:0] ras_top;
  logic            ras_pop_ok;
  logic            redirected_next;
  logic            misalign_next;

`ifdef PC_GEN_RAS_EN
  logic ras_push_q;
  logic ras_pop_q;

  // Calls are recorded even alongside a branch; a return only pops when it actually steers pc.
  assign ras_push_q = ras_push && pc_write && !exc;
  assign ras_pop_q  = ras_pop && pc_write && !exc && !br_taken && !ras_empty;
  assign ras_pop_ok = ras_pop && !ras_empty;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .flush     (exc),
    .push      (ras_push_q),
    .pop       (ras_pop_q),
    .push_addr (ras_push_addr),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  logic unused_ras;

  assign unused_ras = &{1'b0, ras_push, ras_pop, ras_push_addr};
  assign ras_pop_ok = 1'b0;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
`endif

  // Pick the next-PC source and form the value pc takes at the next edge.
  always_comb begin
    src             = SRC_HOLD;
    pc_next         = pc;
    redirected_next = redirected;
    misalign_next   = misalign;
    if (exc)                       src = SRC_EXC;
    else if (br_taken)             src = SRC_BR;
    else if (pc_write && ras_pop_ok) src = SRC_RAS;
    else if (pc_write)             src = SRC_SEQ;
    case (src)
      SRC_EXC: begin
        pc_next         = EXC_VEC & ~LOW_MASK;
        redirected_next = 1'b1;
        misalign_next   = |(EXC_VEC & LOW_MASK);
      end
      SRC_BR: begin
        pc_next         = br_target & ~LOW_MASK;
        redirected_next = 1'b1;
        misalign_next   = |(br_target & LOW_MASK);
      end
      SRC_RAS: begin
        pc_next         = ras_top & ~LOW_MASK;
        redirected_next = 1'b1;
        misalign_next   = |(ras_top & LOW_MASK);
      end
      SRC_SEQ: begin
        pc_next         = pc + XLEN'(STEP);
        redirected_next = 1'b0;
        misalign_next   = 1'b0;
      end
      default: ;
    endcase
  end

  // PC and its status flags; reset forces the reset vector without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_VEC;
      redirected <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      pc         <= pc_next;
      redirected <= redirected_next;
      misalign   <= misalign_next;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random traffic against a queue-based model.
// Latency: model expects the new pc one edge after inputs; pc_next checked before the edge.
// Backpressure: pc_write toggled randomly to exercise stalls.
module tb_pc_gen;
  import pc_pkg::*;

`ifdef PC_GEN_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write, br_taken, exc, ras_push, ras_pop;
  logic [31:0] br_target, ras_push_addr;
  logic [31:0] pc, pc_next;
  logic        redirected, misalign, ras_empty;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: architectural pc/flags and the stack as a queue (back = top).
  logic [31:0] m_pc;
  logic        m_red, m_mis;
  logic [31:0] m_stk[$];

  always #5 clk = ~clk;

  pc_gen dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .exc           (exc),
    .ras_push      (ras_push),
    .ras_push_addr (ras_push_addr),
    .ras_pop       (ras_pop),
    .pc            (pc),
    .pc_next       (pc_next),
    .redirected    (redirected),
    .misalign      (misalign),
    .ras_empty     (ras_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc  = 32'hFFFF_FFFC;
    m_red = 1'b0;
    m_mis = 1'b0;
    m_stk.delete();
  endtask

  task automatic idle_inputs();
    pc_write = 0; br_taken = 0; exc = 0; ras_push = 0; ras_pop = 0;
    br_target = 0; ras_push_addr = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".red"}, {31'b0, redirected}, {31'b0, m_red});
    check({tag, ".mis"}, {31'b0, misalign}, {31'b0, m_mis});
    check({tag, ".empty"}, {31'b0, ras_empty}, {31'b0, (m_stk.size() == 0)});
  endtask

  // Apply current inputs for one clock: predict, check pc_next, clock, check registered state.
  task automatic cycle(input string tag);
    logic [31:0] n_pc;
    logic        n_red, n_mis;
    logic [31:0] n_stk[$];
    n_pc = m_pc; n_red = m_red; n_mis = m_mis; n_stk = m_stk;
    if (exc) begin
      n_pc = 32'h8; n_red = 1; n_mis = 0;
      n_stk.delete();
    end else begin
      if (br_taken) begin
        n_pc = {br_target[31:2], 2'b00}; n_red = 1; n_mis = (br_target[1:0] != 0);
      end else if (pc_write && RAS && ras_pop && n_stk.size() > 0) begin
        n_pc = {n_stk[$][31:2], 2'b00}; n_red = 1; n_mis = (n_stk[$][1:0] != 0);
      end else if (pc_write) begin
        n_pc = m_pc + 32'd4; n_red = 0; n_mis = 0;
      end
      if (pc_write && RAS) begin
        if (!br_taken && ras_pop && n_stk.size() > 0) begin
          if (ras_push) n_stk[n_stk.size()-1] = ras_push_addr;
          else void'(n_stk.pop_back());
        end else if (ras_push) begin
          if (n_stk.size() == DEF_RAS_DEPTH) void'(n_stk.pop_front());
          n_stk.push_back(ras_push_addr);
        end
      end
    end
    #1;
    check({tag, ".pc_next"}, pc_next, n_pc);
    @(posedge clk);
    #1;
    m_pc = n_pc; m_red = n_red; m_mis = n_mis; m_stk = n_stk;
    check_state(tag);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #12;
    check_state("rst");
    @(negedge clk);
    reset = 1'b0;

    // Sequential advance wraps from the reset vector.
    pc_write = 1;
    for (int i = 0; i < 3; i++) cycle("seq");
    check("seq.pc8", pc, 32'h8);

    // Branch to 0x100, then a stalled misaligned branch, then a plain stall.
    br_taken = 1; br_target = 32'h100; cycle("br100");
    pc_write = 0; br_target = 32'h202; cycle("br202");
    check("br202.pc", pc, 32'h200);
    check("br202.mis", {31'b0, misalign}, 32'h1);
    br_taken = 0; cycle("stall");
    check("stall.pc", pc, 32'h200);

    // Exception beats branch.
    exc = 1; br_taken = 1; br_target = 32'h444; cycle("exc");
    check("exc.pc", pc, 32'h8);
    idle_inputs();

`ifdef PC_GEN_RAS_EN
    // Overflow: five pushes into a depth-4 stack, then five pops.
    pc_write = 1;
    for (int i = 1; i <= 5; i++) begin
      ras_push = 1; ras_push_addr = 32'(i * 16); cycle("push");
    end
    ras_push = 0; ras_pop = 1;
    for (int i = 0; i < 4; i++) begin
      cycle("pop");
      check("pop.pc", pc, 32'(80 - 16 * i));
    end
    check("pop4.empty", {31'b0, ras_empty}, 32'h1);
    cycle("pop5");
    check("pop5.pc", pc, 32'h24);
    check("pop5.red", {31'b0, redirected}, 32'h0);

    // Push and pop together swap the top.
    ras_pop = 0; ras_push = 1; ras_push_addr = 32'h40; cycle("push40");
    ras_pop = 1; ras_push_addr = 32'h80; cycle("swap");
    check("swap.pc", pc, 32'h40);
    ras_push = 0; cycle("pop80");
    check("pop80.pc", pc, 32'h80);
    check("pop80.empty", {31'b0, ras_empty}, 32'h1);
    idle_inputs();
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      pc_write      = ($urandom_range(3) != 0);
      br_taken      = ($urandom_range(5) == 0);
      exc           = ($urandom_range(30) == 0);
      ras_push      = ($urandom_range(3) == 0);
      ras_pop       = ($urandom_range(3) == 0);
      br_target     = $urandom;
      ras_push_addr = $urandom;
      cycle("rnd");
    end

    // Asynchronous reset between edges while a branch is pending.
    @(negedge clk);
    idle_inputs();
    pc_write = 1; br_taken = 1; br_target = 32'h300;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst.pc", pc, 32'hFFFF_FFFC);
    model_reset();
    check_state("arst");
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    pc_write = 1;
    cycle("post_rst");
    check("post_rst.pc", pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
